// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bus_arb_pkg;

    // Upper bound on hosts supported by the round-robin search helper
    localparam int unsigned MaxHosts              = 32;
    localparam int unsigned NrHostsDefault        = 2;
    localparam int unsigned MaxOutstandingDefault = 4;

    // Index width for n items; a single item still needs one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned HostIdxWidth = idx_width(NrHostsDefault);
    typedef logic [HostIdxWidth-1:0] host_idx_t;

    // First set bit of req searching upward from ptr, wrapping modulo n.
    // Returns ptr when nothing is requesting.
    function automatic logic [31:0] rr_next(input logic [MaxHosts-1:0] req,
                                            input logic [31:0]         ptr,
                                            input logic [31:0]         n);
        logic [31:0] idx;
        logic [31:0] win;
        win = ptr;
        // Walk downward so the lowest offset from ptr is written last and wins
        for (int i = MaxHosts - 1; i >= 0; i--) begin
            idx = ptr + 32'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((32'(i) < n) && req[idx[4:0]]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host IDs for accepted-but-unanswered transactions.
// Latency: push visible at head next cycle; head/count are registered.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on count.
module bus_arb_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic [Width-1:0]               data_i,
    input  logic                           pop_i,
    output logic [$clog2(Depth+1)-1:0]     count_o,
    output logic [Width-1:0]               head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CntW'(Depth));
    assign w_empty = (r_count == '0);
    assign w_push  = push_i & ~w_full;
    assign w_pop   = pop_i & ~w_empty;
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

    // Storage write; contents are meaningless until counted, so no reset
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping, both pointers wrap at Depth
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one OBI device port between NrHosts hosts; routes responses back in order.
// Latency: zero-cycle request path (gnt same cycle) and zero-cycle response routing.
// Backpressure: grant locked to one host while the device stalls; no requests while MaxOutstanding are pending.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = NrHostsDefault,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NrHosts-1:0]                      host_req_i,
    output logic [NrHosts-1:0]                      host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
    input  logic [NrHosts-1:0]                      host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
    output logic [NrHosts-1:0]                      host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
    output logic [NrHosts-1:0]                      host_err_o,
    output logic                                    dev_req_o,
    input  logic                                    dev_gnt_i,
    output logic [AddressWidth-1:0]                 dev_addr_o,
    output logic                                    dev_we_o,
    output logic [DataWidth/8-1:0]                  dev_be_o,
    output logic [DataWidth-1:0]                    dev_wdata_o,
    input  logic                                    dev_rvalid_i,
    input  logic [DataWidth-1:0]                    dev_rdata_i,
    input  logic                                    dev_err_i,
    output logic                                    resp_unexp_o
);

    localparam int unsigned IdW  = idx_width(NrHosts);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdW-1:0]  r_rr_ptr;
    logic            r_lock;
    logic [IdW-1:0]  r_locked_id;
    logic            r_resp_unexp;

    logic [31:0]     w_rr_win;
    logic [IdW-1:0]  w_winner;
    logic            w_full;
    logic            w_hs;
    logic            w_pop;
    logic [CntW-1:0] w_count;
    logic [IdW-1:0]  w_head;
    logic            w_has_out;

    assign w_rr_win  = rr_next(32'(host_req_i), 32'(r_rr_ptr), 32'(NrHosts));
    assign w_winner  = r_lock ? r_locked_id : w_rr_win[IdW-1:0];
    assign w_full    = (w_count == CntW'(MaxOutstanding));
    assign w_has_out = (w_count != '0);

    assign dev_req_o   = (|host_req_i) & ~w_full;
    assign w_hs        = dev_req_o & dev_gnt_i;
    assign dev_addr_o  = host_addr_i[w_winner];
    assign dev_we_o    = host_we_i[w_winner];
    assign dev_be_o    = host_be_i[w_winner];
    assign dev_wdata_o = host_wdata_i[w_winner];

    // Responses always belong to the oldest outstanding transaction
    assign w_pop        = dev_rvalid_i & w_has_out;
    assign host_rdata_o = {NrHosts{dev_rdata_i}};
    assign resp_unexp_o = r_resp_unexp;

    // Steer grant to the winner and the response to the FIFO head
    always_comb begin
        host_gnt_o              = '0;
        host_rvalid_o           = '0;
        host_err_o              = '0;
        host_gnt_o[w_winner]    = w_hs;
        host_rvalid_o[w_head]   = w_pop;
        host_err_o[w_head]      = w_pop & dev_err_i;
    end

    // Round-robin pointer moves past the winner only on an accepted request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= (w_winner == IdW'(NrHosts - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    // Freeze the winner while the device stalls so request fields stay stable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock      <= 1'b0;
            r_locked_id <= '0;
        end else if (dev_req_o && !dev_gnt_i) begin
            r_lock      <= 1'b1;
            r_locked_id <= w_winner;
        end else if (w_hs) begin
            r_lock      <= 1'b0;
        end
    end

    // Sticky flag for responses arriving with nothing outstanding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_unexp <= 1'b0;
        end else if (dev_rvalid_i && !w_has_out) begin
            r_resp_unexp <= 1'b1;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_hs),
        .data_i  (w_winner),
        .pop_i   (w_pop),
        .count_o (w_count),
        .head_o  (w_head)
    );

endmodule
